// File: rtl/pcap_ring_sched.sv
// rtl/pcap_ring_sched.sv - packet-capture ring scheduler driving the DMA writer
// Optional writer/skip watchdog: define PCAP_WDOG_EN.
module pcap_ring_sched #(
  parameter int HDR_BYTES   = 16,
  parameter int MAX_PKT     = 2048,
  parameter int WDOG_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] ring_base,
  input  logic [31:0] ring_size,
  input  logic [31:0] rd_off,
  input  logic        drop_en,
  input  logic        desc_valid,
  input  logic [15:0] desc_len,
  output logic        desc_ready,
  output logic        skip_req,
  output logic [15:0] skip_len,
  input  logic        skip_done,
  output logic        wr_start,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_pkt_begin,
  output logic [31:0] wr_pkt_end,
  input  logic        wr_rdy,
  output logic [31:0] wr_off,
  output logic [31:0] pkt_cnt,
  output logic [31:0] drop_cnt,
  output logic [15:0] wrap_cnt,
  output logic        busy,
  output logic        err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_EVAL  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_ADV   = 3'd4;
  localparam logic [2:0] S_DROP  = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [31:0] start_q, start_d;
  logic [31:0] rec16_q, rec16_d;
  logic        wrap_q, wrap_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_pkt_end_q, wr_pkt_end_d;
  logic [15:0] skip_len_q, skip_len_d;
  logic [31:0] wr_off_q, wr_off_d;
  logic [31:0] pkt_cnt_q, pkt_cnt_d;
  logic [31:0] drop_cnt_q, drop_cnt_d;
  logic [15:0] wrap_cnt_q, wrap_cnt_d;
  logic        timeout;

  logic [31:0] len32, rec, rec16, used, free, need, adv_off;
  logic        wraps, len_bad;

  // Record geometry and ring occupancy for the descriptor at the head of the queue.
  always_comb begin
    len32   = {16'd0, desc_len};
    rec     = 32'(HDR_BYTES) + ((len32 + 32'd3) & ~32'd3);
    rec16   = (rec + 32'd15) & ~32'd15;
    used    = (wr_off_q >= rd_off) ? (wr_off_q - rd_off) : (ring_size - rd_off + wr_off_q);
    free    = ring_size - used - 32'd16;
    wraps   = (wr_off_q + rec16) > ring_size;
    need    = wraps ? (ring_size - wr_off_q + rec16) : rec16;
    len_bad = (desc_len == 16'd0) || (len32 > 32'(MAX_PKT));
    adv_off = start_q + rec16_q;
  end

`ifdef PCAP_WDOG_EN
  logic [31:0] wdog_q, wdog_d;
  logic        err_q, err_d;
  // A completion arriving on the last allowed cycle still wins over the timeout.
  always_comb begin
    wdog_d  = ((state_q == S_WAIT) || (state_q == S_DROP)) ? wdog_q + 32'd1 : 32'd0;
    timeout = (wdog_q == 32'(WDOG_CYCLES - 1)) &&
              (((state_q == S_WAIT) && !wr_rdy) || ((state_q == S_DROP) && !skip_done));
    err_d   = err_q | timeout;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      wdog_q <= 32'd0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end
  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    start_d      = start_q;
    rec16_d      = rec16_q;
    wrap_d       = wrap_q;
    wr_addr_d    = wr_addr_q;
    wr_pkt_end_d = wr_pkt_end_q;
    skip_len_d   = skip_len_q;
    wr_off_d     = wr_off_q;
    pkt_cnt_d    = pkt_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    wrap_cnt_d   = wrap_cnt_q;
    case (state_q)
      S_IDLE: if (enable && desc_valid) state_d = S_EVAL;
      S_EVAL: begin
        if (len_bad || ((free < need) && drop_en)) begin
          skip_len_d = desc_len;
          state_d    = S_DROP;
        end else if (free >= need) begin
          start_d      = wraps ? 32'd0 : wr_off_q;
          rec16_d      = rec16;
          wrap_d       = wraps;
          wr_addr_d    = ring_base + (wraps ? 32'd0 : wr_off_q);
          wr_pkt_end_d = len32;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (wrap_q) begin
          wr_off_d   = 32'd0;
          wrap_cnt_d = (wrap_cnt_q == 16'hFFFF) ? wrap_cnt_q : wrap_cnt_q + 16'd1;
        end
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wr_rdy) begin
          state_d = S_ADV;
        end else if (timeout) begin
          drop_cnt_d = (drop_cnt_q == 32'hFFFF_FFFF) ? drop_cnt_q : drop_cnt_q + 32'd1;
          state_d    = S_IDLE;
        end
      end
      S_ADV: begin
        wr_off_d  = (adv_off == ring_size) ? 32'd0 : adv_off;
        pkt_cnt_d = (pkt_cnt_q == 32'hFFFF_FFFF) ? pkt_cnt_q : pkt_cnt_q + 32'd1;
        state_d   = S_IDLE;
      end
      S_DROP: begin
        if (skip_done || timeout) begin
          drop_cnt_d = (drop_cnt_q == 32'hFFFF_FFFF) ? drop_cnt_q : drop_cnt_q + 32'd1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      start_q      <= 32'd0;
      rec16_q      <= 32'd0;
      wrap_q       <= 1'b0;
      wr_addr_q    <= 32'd0;
      wr_pkt_end_q <= 32'd0;
      skip_len_q   <= 16'd0;
      wr_off_q     <= 32'd0;
      pkt_cnt_q    <= 32'd0;
      drop_cnt_q   <= 32'd0;
      wrap_cnt_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      rec16_q      <= rec16_d;
      wrap_q       <= wrap_d;
      wr_addr_q    <= wr_addr_d;
      wr_pkt_end_q <= wr_pkt_end_d;
      skip_len_q   <= skip_len_d;
      wr_off_q     <= wr_off_d;
      pkt_cnt_q    <= pkt_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      wrap_cnt_q   <= wrap_cnt_d;
    end
  end

  // The pop is combinational so the FIFO advances before IDLE samples desc_valid again.
  assign desc_ready   = (state_q == S_ADV) || ((state_q == S_DROP) && skip_done) || timeout;
  assign wr_start     = (state_q == S_ISSUE);
  assign skip_req     = (state_q == S_DROP);
  assign busy         = (state_q != S_IDLE);
  assign skip_len     = skip_len_q;
  assign wr_addr      = wr_addr_q;
  assign wr_pkt_begin = 32'd0;
  assign wr_pkt_end   = wr_pkt_end_q;
  assign wr_off       = wr_off_q;
  assign pkt_cnt      = pkt_cnt_q;
  assign drop_cnt     = drop_cnt_q;
  assign wrap_cnt     = wrap_cnt_q;

endmodule

// File: tb/tb_pcap_ring_sched.sv
// tb/tb_pcap_ring_sched.sv - randomized self-checking bench for pcap_ring_sched
module tb_pcap_ring_sched;
  localparam int unsigned BASE = 32'h1000;
  localparam int unsigned SIZE = 32'h400;
  localparam int unsigned HDR  = 16;

  logic clk = 1'b0;
  logic reset, enable, drop_en, desc_valid, skip_done, wr_rdy;
  logic [31:0] ring_base, ring_size, rd_off;
  logic [15:0] desc_len;
  logic desc_ready, skip_req, wr_start, busy, err;
  logic [15:0] skip_len, wrap_cnt;
  logic [31:0] wr_addr, wr_pkt_begin, wr_pkt_end, wr_off, pkt_cnt, drop_cnt;

  int total = 0;
  int bad = 0;
  int unsigned m_off, m_pkt, m_drop, m_wrap;

  always #5 clk = ~clk;

  pcap_ring_sched #(.HDR_BYTES(16), .MAX_PKT(2048), .WDOG_CYCLES(100)) dut (
    .clk(clk), .reset(reset), .enable(enable), .ring_base(ring_base), .ring_size(ring_size),
    .rd_off(rd_off), .drop_en(drop_en), .desc_valid(desc_valid), .desc_len(desc_len),
    .desc_ready(desc_ready), .skip_req(skip_req), .skip_len(skip_len), .skip_done(skip_done),
    .wr_start(wr_start), .wr_addr(wr_addr), .wr_pkt_begin(wr_pkt_begin), .wr_pkt_end(wr_pkt_end),
    .wr_rdy(wr_rdy), .wr_off(wr_off), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt),
    .wrap_cnt(wrap_cnt), .busy(busy), .err(err)
  );

  // kind: 0 = issue, 1 = drop, 2 = stall
  function automatic void predict(input int unsigned len, input int unsigned rd, input bit de,
                                  output int kind, output int unsigned start,
                                  output int unsigned rec16, output bit wraps);
    int unsigned used, free, need;
    rec16 = ((HDR + ((len + 3) / 4) * 4 + 15) / 16) * 16;
    used  = (m_off + SIZE - rd) % SIZE;
    free  = SIZE - used - 16;
    wraps = (m_off + rec16) > SIZE;
    start = wraps ? 0 : m_off;
    need  = wraps ? (SIZE - m_off + rec16) : rec16;
    if (len == 0 || len > 2048) kind = 1;
    else if (free >= need)      kind = 0;
    else if (de)                kind = 1;
    else                        kind = 2;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; enable = 1'b0; drop_en = 1'b0; desc_valid = 1'b0; desc_len = 16'd0;
    skip_done = 1'b0; wr_rdy = 1'b0; rd_off = 32'd0;
    ring_base = BASE; ring_size = SIZE;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    m_off = 0; m_pkt = 0; m_drop = 0; m_wrap = 0;
  endtask

  task automatic finish_counts(input string tag);
    total++;
    if (wr_off !== m_off || pkt_cnt !== m_pkt || drop_cnt !== m_drop || wrap_cnt !== m_wrap[15:0] || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s counters got off=%0h pkt=%0d drop=%0d wrap=%0d busy=%b exp off=%0h pkt=%0d drop=%0d wrap=%0d busy=0",
               tag, wr_off, pkt_cnt, drop_cnt, wrap_cnt, busy, m_off, m_pkt, m_drop, m_wrap);
    end
  endtask

  task automatic run_pkt(input int unsigned len, input bit de, input int unsigned rd,
                         input int unsigned rd_rel, input string tag);
    int kind; int unsigned start, rec16; bit wraps; bit seen; int lat;
    @(negedge clk);
    enable = 1'b1; drop_en = de; rd_off = rd; desc_len = len[15:0]; desc_valid = 1'b1;
    predict(len, rd, de, kind, start, rec16, wraps);
    if (kind == 2) begin
      repeat (3 + $urandom_range(0, 4)) begin
        @(negedge clk);
        total++;
        if (wr_start !== 1'b0 || skip_req !== 1'b0 || busy !== 1'b1) begin
          bad++;
          $display("FAIL %s stall got start=%b skip=%b busy=%b exp 0 0 1", tag, wr_start, skip_req, busy);
        end
      end
      rd_off = rd_rel;
      predict(len, rd_rel, de, kind, start, rec16, wraps);
    end
    if (kind == 0) begin
      seen = 1'b0;
      for (int i = 0; i < 4 && !seen; i++) begin
        @(negedge clk);
        seen = wr_start;
      end
      total++;
      if (!seen) begin
        bad++;
        $display("FAIL %s wr_start timeout got=0 exp=1", tag);
        do_reset();
        return;
      end
      total++;
      if (wr_addr !== BASE + start || wr_pkt_end !== len || wr_pkt_begin !== 32'd0 || desc_ready !== 1'b0) begin
        bad++;
        $display("FAIL %s issue got addr=%0h end=%0d begin=%0h rdy=%b exp addr=%0h end=%0d begin=0 rdy=0",
                 tag, wr_addr, wr_pkt_end, wr_pkt_begin, desc_ready, BASE + start, len);
      end
      lat = $urandom_range(1, 5);
      repeat (lat) begin
        @(negedge clk);
        total++;
        if (wr_start !== 1'b0 || wr_addr !== BASE + start || wr_pkt_end !== len || desc_ready !== 1'b0) begin
          bad++;
          $display("FAIL %s wait got start=%b addr=%0h end=%0d rdy=%b exp 0 %0h %0d 0",
                   tag, wr_start, wr_addr, wr_pkt_end, desc_ready, BASE + start, len);
        end
      end
      wr_rdy = 1'b1;
      @(negedge clk);
      wr_rdy = 1'b0;
      total++;
      if (desc_ready !== 1'b1) begin
        bad++;
        $display("FAIL %s advance desc_ready got=%b exp=1", tag, desc_ready);
      end
      desc_valid = 1'b0;
      if (wraps) m_wrap++;
      m_off = (start + rec16 == SIZE) ? 0 : start + rec16;
      m_pkt++;
      @(negedge clk);
      finish_counts(tag);
    end else begin
      seen = 1'b0;
      for (int i = 0; i < 4 && !seen; i++) begin
        @(negedge clk);
        seen = skip_req;
      end
      total++;
      if (!seen) begin
        bad++;
        $display("FAIL %s skip_req timeout got=0 exp=1", tag);
        do_reset();
        return;
      end
      total++;
      if (skip_len !== len[15:0] || wr_start !== 1'b0 || desc_ready !== 1'b0) begin
        bad++;
        $display("FAIL %s drop got skip_len=%0d start=%b rdy=%b exp %0d 0 0", tag, skip_len, wr_start, desc_ready, len[15:0]);
      end
      repeat ($urandom_range(0, 4)) @(negedge clk);
      skip_done = 1'b1;
      #1;
      total++;
      if (desc_ready !== 1'b1 || wr_start !== 1'b0) begin
        bad++;
        $display("FAIL %s drop pop got rdy=%b start=%b exp 1 0", tag, desc_ready, wr_start);
      end
      @(negedge clk);
      skip_done = 1'b0;
      desc_valid = 1'b0;
      m_drop++;
      @(negedge clk);
      finish_counts(tag);
    end
  endtask

  task automatic test_reset();
    bit seen;
    do_reset();
    @(negedge clk);
    total++;
    if ({desc_ready, skip_req, skip_len, wr_start, wr_addr, wr_pkt_begin, wr_pkt_end, wr_off,
         pkt_cnt, drop_cnt, wrap_cnt, busy, err} !== '0) begin
      bad++;
      $display("FAIL reset outputs got nonzero off=%0h addr=%0h busy=%b exp all zero", wr_off, wr_addr, busy);
    end
    enable = 1'b1; desc_len = 16'd60; desc_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clk);
      seen = wr_start;
    end
    @(negedge clk);
    reset = 1'b0; desc_valid = 1'b0;
    @(negedge clk);
    wr_rdy = 1'b1;
    @(negedge clk);
    wr_rdy = 1'b0;
    total++;
    if (!seen || wr_off !== 32'd0 || pkt_cnt !== 32'd0 || busy !== 1'b0 || wr_addr !== 32'd0 || desc_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid got seen=%b off=%0h pkt=%0d busy=%b addr=%0h rdy=%b exp 1 0 0 0 0 0",
               seen, wr_off, pkt_cnt, busy, wr_addr, desc_ready);
    end
    do_reset();
  endtask

  task automatic test_basic();
    run_pkt(60, 1'b0, 32'h0, 32'h0, "basic");
    total++;
    if (wr_off !== 32'h50 || pkt_cnt !== 32'd1) begin
      bad++;
      $display("FAIL basic_const got off=%0h pkt=%0d exp 50 1", wr_off, pkt_cnt);
    end
  endtask

  task automatic test_wrap();
    run_pkt(864, 1'b0, 32'h50, 32'h50, "fill");
    total++;
    if (wr_off !== 32'h3C0) begin
      bad++;
      $display("FAIL fill_const got off=%0h exp 3c0", wr_off);
    end
    run_pkt(64, 1'b0, 32'h200, 32'h200, "wrap");
    total++;
    if (wr_off !== 32'h50 || wrap_cnt !== 16'd1) begin
      bad++;
      $display("FAIL wrap_const got off=%0h wrap=%0d exp 50 1", wr_off, wrap_cnt);
    end
  endtask

  task automatic test_stall();
    do_reset();
    run_pkt(48, 1'b0, 32'h0, 32'h0, "pre_stall");
    run_pkt(100, 1'b0, 32'h60, 32'h3F0, "stall");
    total++;
    if (wr_off !== 32'hC0 || pkt_cnt !== 32'd2) begin
      bad++;
      $display("FAIL stall_const got off=%0h pkt=%0d exp c0 2", wr_off, pkt_cnt);
    end
  endtask

  task automatic test_drop();
    run_pkt(100, 1'b1, 32'hE0, 32'hE0, "drop_full");
    total++;
    if (drop_cnt !== 32'd1 || wr_off !== 32'hC0) begin
      bad++;
      $display("FAIL drop_const got drop=%0d off=%0h exp 1 c0", drop_cnt, wr_off);
    end
  endtask

  task automatic test_illegal();
    run_pkt(0, 1'b0, m_off, m_off, "len0");
    run_pkt(3000, 1'b0, m_off, m_off, "len3000");
    total++;
    if (drop_cnt !== 32'd3) begin
      bad++;
      $display("FAIL illegal_const got drop=%0d exp 3", drop_cnt);
    end
  endtask

  task automatic test_random();
    int unsigned len, r, sel;
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      len = 0;
      else if (sel == 1) len = $urandom_range(2049, 65535);
      else               len = $urandom_range(1, 400);
      r = $urandom_range(0, 63) * 16;
      run_pkt(len, $urandom_range(0, 1) == 1, r, m_off, "random");
    end
  endtask

`ifdef PCAP_WDOG_EN
  task automatic test_wdog();
    int cyc; bit seen;
    do_reset();
    @(negedge clk);
    enable = 1'b1; desc_len = 16'd60; desc_valid = 1'b1; rd_off = 32'd0;
    cyc = 0; seen = 1'b0;
    while (cyc < 200 && !seen) begin
      @(negedge clk);
      cyc++;
      seen = desc_ready;
    end
    desc_valid = 1'b0;
    total++;
    if (!seen || cyc < 100 || cyc > 104) begin
      bad++;
      $display("FAIL wdog_time got seen=%b cycles=%0d exp 1 in 100..104", seen, cyc);
    end
    m_drop++;
    @(negedge clk);
    total++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL wdog_err got=%b exp=1", err);
    end
    finish_counts("wdog");
    run_pkt(60, 1'b0, 32'h0, 32'h0, "after_wdog");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_drop();
    test_illegal();
    test_random();
`ifdef PCAP_WDOG_EN
    test_wdog();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
